// File: rtl/prime_pkg.sv
// =============================================================================
// Module  : prime_pkg
// Purpose : Shared state encoding, seed constants and width helper for the
//           trial-division primality checker.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

package prime_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLASSIFY = 3'd1,
        ST_BOUND    = 3'd2,
        ST_DIV      = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam int FIRST_ODD_DIV = 3;
    localparam int FIRST_SQ      = 9;

    // The running d*d register needs twice the candidate width.
    function automatic int sq_width(input int w);
        return 2 * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mod_div.sv
// =============================================================================
// Module  : seq_mod_div
// Purpose : Bit-serial restoring remainder unit; one dividend bit per cycle,
//           done/rem valid combinationally in the WIDTH-th cycle after start.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

module seq_mod_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] rem
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;

    // Partial remainder is always below the divisor, so the top diff bit is a clean borrow flag.
    assign w_trial = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_div};
    assign rem     = w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign done    = r_busy && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd  <= '0;
            r_div  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_dvd  <= dividend;
            r_div  <= divisor;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem  <= rem;
            r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt + CW'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prime_checker.sv
// =============================================================================
// Module  : prime_checker
// Purpose : Trial-division primality checker with valid/ready in and out.
//           Define PRIME_CHECK_FACTOR_EN to report the smallest factor.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

module prime_checker
    import prime_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cand_valid,
    output logic             cand_ready,
    input  logic [WIDTH-1:0] cand,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_is_prime,
    output logic [WIDTH-1:0] res_value,
    output logic [WIDTH-1:0] res_factor
);

    localparam int SQW = sq_width(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_d;
    logic [SQW-1:0]   r_sq;
    logic             r_is_prime;

    logic             w_small;
    logic             w_tiny_prime;
    logic             w_fast;
    logic             w_sq_gt;
    logic             w_div_start;
    logic             w_div_done;
    logic [WIDTH-1:0] w_rem;
    logic             w_rem_zero;

    assign w_small      = r_n < WIDTH'(2);
    assign w_tiny_prime = (r_n == WIDTH'(2)) || (r_n == WIDTH'(3));
    assign w_fast       = w_small || w_tiny_prime || !r_n[0];
    assign w_sq_gt      = r_sq > SQW'(r_n);
    assign w_rem_zero   = (w_rem == '0);

    seq_mod_div #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_div_start),
        .dividend (r_n),
        .divisor  (r_d),
        .done     (w_div_done),
        .rem      (w_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (cand_valid) w_next = ST_CLASSIFY;
            ST_CLASSIFY: w_next = w_fast ? ST_DONE : ST_BOUND;
            ST_BOUND:    w_next = w_sq_gt ? ST_DONE : ST_DIV;
            ST_DIV:      if (w_div_done) w_next = w_rem_zero ? ST_DONE : ST_BOUND;
            ST_DONE:     if (res_ready) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cand_ready  = (r_state == ST_IDLE);
        res_valid   = (r_state == ST_DONE);
        w_div_start = (r_state == ST_BOUND) && !w_sq_gt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n        <= '0;
            r_d        <= WIDTH'(FIRST_ODD_DIV);
            r_sq       <= SQW'(FIRST_SQ);
            r_is_prime <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cand_valid) begin
                        r_n  <= cand;
                        r_d  <= WIDTH'(FIRST_ODD_DIV);
                        r_sq <= SQW'(FIRST_SQ);
                    end
                end
                ST_CLASSIFY: r_is_prime <= w_tiny_prime;
                ST_BOUND: begin
                    if (w_sq_gt) begin
                        r_is_prime <= 1'b1;
                    end
                end
                ST_DIV: begin
                    if (w_div_done && !w_rem_zero) begin
                        // (d+2)^2 = d^2 + 4d + 4, using the pre-increment d.
                        r_d  <= r_d + WIDTH'(2);
                        r_sq <= r_sq + (SQW'(r_d) << 2) + SQW'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_is_prime = r_is_prime;
    assign res_value    = r_n;

`ifdef PRIME_CHECK_FACTOR_EN
    logic [WIDTH-1:0] r_factor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_factor <= '0;
        end else begin
            case (r_state)
                ST_CLASSIFY: r_factor <= w_small ? '0 : (w_tiny_prime ? r_n : WIDTH'(2));
                ST_BOUND:    if (w_sq_gt) r_factor <= r_n;
                ST_DIV:      if (w_div_done && w_rem_zero) r_factor <= r_d;
                default: ;
            endcase
        end
    end

    assign res_factor = r_factor;
`else
    assign res_factor = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prime_checker.sv
// =============================================================================
// Module  : tb_prime_checker
// Purpose : Directed self-checking bench for prime_checker at WIDTH=16.
// Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_prime_checker;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         cand_valid;
    logic         cand_ready;
    logic [W-1:0] cand;
    logic         res_valid;
    logic         res_ready;
    logic         res_is_prime;
    logic [W-1:0] res_value;
    logic [W-1:0] res_factor;

    int total = 0;
    int bad   = 0;

    prime_checker #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cand_valid   (cand_valid),
        .cand_ready   (cand_ready),
        .cand         (cand),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_is_prime (res_is_prime),
        .res_value    (res_value),
        .res_factor   (res_factor)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] exp_factor(input logic [W-1:0] n, input logic [W-1:0] f);
`ifdef PRIME_CHECK_FACTOR_EN
        exp_factor = f;
`else
        exp_factor = '0;
`endif
    endfunction

    function automatic logic [W-1:0] ref_smallest(input logic [W-1:0] n);
        int v;
        v = int'(n);
        if (v < 2) return '0;
        for (int k = 2; k * k <= v; k++) begin
            if (v % k == 0) return W'(k);
        end
        return n;
    endfunction

    // Offers n, measures edges from acceptance to res_valid, then holds the
    // verdict for 'hold' cycles before completing the result handshake.
    task automatic send(input logic [W-1:0] n, input int hold,
                        output logic p, output logic [W-1:0] v,
                        output logic [W-1:0] f, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!cand_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        cand_valid = 1'b1;
        cand       = n;
        @(posedge clk);
        #1;
        cand_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 5000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!res_valid) lat = -1;
        p = res_is_prime;
        v = res_value;
        f = res_factor;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        cand_valid = 1'b0;
        cand       = '0;
        res_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cand_ready, res_valid, res_is_prime, res_value, res_factor} !== {1'b1, 1'b0, 1'b0, 16'd0, 16'd0}) begin
            bad++;
            $display("FAIL reset_values: got rdy=%b vld=%b prime=%b val=%0d fac=%0d, want 1 0 0 0 0",
                     cand_ready, res_valid, res_is_prime, res_value, res_factor);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (cand_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got rdy=%b vld=%b, want 1 0", cand_ready, res_valid);
        end
    endtask

    task automatic test_vectors;
        logic [W-1:0] tn [11]  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd100, 16'd5, 16'd9, 16'd11, 16'd25, 16'd65521, 16'd65535};
        logic         tp [11]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] tf [11]  = '{16'd0, 16'd0, 16'd2, 16'd3, 16'd2, 16'd5, 16'd3, 16'd11, 16'd5, 16'd65521, 16'd3};
        int           tl [11]  = '{1, 1, 1, 1, 1, 2, 18, 19, 35, 2161, 18};
        logic         p;
        logic [W-1:0] v, f;
        int           lat;
        for (int i = 0; i < 11; i++) begin
            send(tn[i], 0, p, v, f, lat);
            total++;
            if (p !== tp[i] || v !== tn[i] || f !== exp_factor(tn[i], tf[i]) || lat != tl[i]) begin
                bad++;
                $display("FAIL vector_n%0d: got prime=%b val=%0d fac=%0d L=%0d, want prime=%b val=%0d fac=%0d L=%0d",
                         tn[i], p, v, f, lat, tp[i], tn[i], exp_factor(tn[i], tf[i]), tl[i]);
            end
        end
    endtask

    task automatic test_reset_mid_div;
        int seen;
        @(negedge clk);
        cand_valid = 1'b1;
        cand       = 16'd49;
        @(posedge clk);
        #1;
        cand_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (cand_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_div: got rdy=%b vld=%b, want 1 0", cand_ready, res_valid);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (res_valid) seen++;
        end
        total++;
        if (seen != 0 || cand_ready !== 1'b1) begin
            bad++;
            $display("FAIL no_verdict_after_reset: got valid_cycles=%0d rdy=%b, want 0 1", seen, cand_ready);
        end
    endtask

    task automatic test_backpressure;
        int           lat;
        int           unstable;
        logic [W-1:0] f0;
        @(negedge clk);
        cand_valid = 1'b1;
        cand       = 16'd15;
        @(posedge clk);
        #1;
        cand_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 5000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        f0 = res_factor;
        total++;
        if (res_valid !== 1'b1 || res_is_prime !== 1'b0 || res_value !== 16'd15 || f0 !== exp_factor(16'd15, 16'd3)) begin
            bad++;
            $display("FAIL bp_verdict: got vld=%b prime=%b val=%0d fac=%0d, want 1 0 15 %0d",
                     res_valid, res_is_prime, res_value, f0, exp_factor(16'd15, 16'd3));
        end
        @(negedge clk);
        cand_valid = 1'b1;
        cand       = 16'd7;
        unstable   = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (res_valid !== 1'b1 || res_is_prime !== 1'b0 || res_value !== 16'd15 ||
                res_factor !== f0 || cand_ready !== 1'b0) unstable++;
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL bp_hold: got %0d unstable cycles, want 0", unstable);
        end
        @(negedge clk);
        cand_valid = 1'b0;
        res_ready  = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        total++;
        if (cand_ready !== 1'b1 || res_valid !== 1'b0 || res_value !== 16'd15) begin
            bad++;
            $display("FAIL bp_release: got rdy=%b vld=%b val=%0d, want 1 0 15", cand_ready, res_valid, res_value);
        end
        @(negedge clk);
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        res_ready = 1'b0;
        total++;
        if (cand_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL res_ready_idle: got rdy=%b vld=%b, want 1 0", cand_ready, res_valid);
        end
    endtask

    task automatic test_stream;
        logic [W-1:0] primes [20] = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd11, 16'd13, 16'd17, 16'd19, 16'd23, 16'd29,
                                       16'd31, 16'd37, 16'd41, 16'd43, 16'd47, 16'd53, 16'd59, 16'd61, 16'd67, 16'd71};
        logic [W-1:0] n, v, f, ef;
        logic         p, ep;
        int           lat, a, b;
        for (int i = 0; i < 40; i++) begin
            if (i < 20) begin
                n = primes[i];
            end else begin
                a = int'($urandom_range(2, 255));
                b = int'($urandom_range(2, 255));
                n = W'(a * b);
            end
            ef = ref_smallest(n);
            ep = (n >= 16'd2) && (ef == n);
            send(n, int'($urandom_range(0, 3)), p, v, f, lat);
            total++;
            if (lat < 0 || p !== ep || v !== n || f !== exp_factor(n, ef)) begin
                bad++;
                $display("FAIL stream_%0d: got n=%0d prime=%b fac=%0d L=%0d, want n=%0d prime=%b fac=%0d",
                         i, v, p, f, lat, n, ep, exp_factor(n, ef));
            end
        end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_reset_mid_div;
        test_backpressure;
        test_stream;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
